ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable)
//  from the FPGA to the keyboard over the shared open-drain PS2_CLK/PS2_DAT lines. Counterpart of the
//  blackjack PS/2 receiver; instantiated beside it under blackjack_top, and busy gates the receiver.
//  Drives lines only via active-high pull-low enables; the top level forms PS2_x = oe ? 1'b0 : 1'bz.
// PARAMETERS
//  INHIBIT_CYCLES  6000     CLOCK_50 cycles the clock is held low before the start bit (120 us)
//  TIMEOUT_CYCLES  750000   max cycles waiting for any device clock edge or line release (15 ms)
//  SYNC_STAGES     2        flip-flop stages on ps2_clk_in / ps2_dat_in
// PORTS
//  CLOCK_50     in   1  system clock, 50 MHz
//  rst_n        in   1  asynchronous active-low reset
//  tx_data      in   8  command byte; sampled when tx_valid && tx_ready
//  tx_valid     in   1  request to send tx_data
//  tx_ready     out  1  high only in IDLE
//  busy         out  1  high in every state except IDLE; the receiver ignores the lines while high
//  tx_done      out  1  1-cycle pulse, transfer acknowledged by the device
//  tx_error     out  1  1-cycle pulse, missing ACK or timeout
//  ps2_clk_in   in   1  raw PS2_CLK level
//  ps2_dat_in   in   1  raw PS2_DAT level
//  ps2_clk_oe   out  1  1 = pull PS2_CLK low
//  ps2_dat_oe   out  1  1 = pull PS2_DAT low
// BEHAVIOUR
//  Reset (async, any state): IDLE; tx_ready=1; busy=0; tx_done=0; tx_error=0; both oe=0 (lines released).
//  Inputs are synchronized through SYNC_STAGES flops. fall = synced clk 1->0, one-cycle pulse.
//  Frame = start(0), d0..d7 (LSB first), odd parity (~^tx_data), stop(1), then device ACK(0).
//  FSM:
//   IDLE    : on tx_valid, latch tx_data and parity, clear bit_cnt; clk_oe=1 -> INHIBIT.
//   INHIBIT : clk_oe=1 for INHIBIT_CYCLES; in the final cycle dat_oe=1 (start bit); next cycle clk_oe=0 -> SEND.
//   SEND    : on fall k: k=1..8 -> dat_oe=~tx_data[k-1]; k=9 -> dat_oe=~parity; k=10 -> dat_oe=0 (stop).
//             After fall 10 -> ACK.
//   ACK     : on fall 11, sample synced dat: 0 -> WAIT_IDLE; 1 -> ERR.
//   WAIT_IDLE: wait until synced clk=1 and dat=1 -> DONE.
//   DONE    : tx_done=1 for one cycle -> IDLE.   ERR: release both lines, tx_error=1 for one cycle -> IDLE.
//  Timeout: an 20-bit cycle counter reloads on every fall and on each state entry. If it reaches
//   TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE, go to ERR; the lines are released the same cycle.
//  tx_valid while busy: ignored, no queueing; the request must be re-presented in IDLE.
//  Simultaneous tx_valid and DONE/ERR exit: the request is accepted only on the next cycle (in IDLE).
//  Device clock edges in IDLE/INHIBIT are ignored; the host holds priority once in INHIBIT.
//  dat_oe changes only in the cycle after a detected fall, so data is stable across the device's rising edge.
//  Reset mid-frame: lines released immediately; the device sees a truncated frame and times out on its side.
//  Widths: bit_cnt 4 bits (0..11); inhibit counter sized for INHIBIT_CYCLES; no arithmetic on tx_data.
// STRUCTURE
//  Shared package blackjack_ps2_pkg: state encodings, the command constants PS2_CMD_SET_LEDS=8'hED,
//   PS2_CMD_RESET=8'hFF and PS2_CMD_ENABLE=8'hF4, and PS2_ACK_BYTE=8'hFA (consumed by the receiver side).
//  One sub-module, ps2_sync_edge: SYNC_STAGES synchronizer plus falling-edge pulse, also reused by the receiver.
//  The top level owns the tristate buffers; this block contains no inout ports.
// TESTING  (bench device model: 12.5 kHz clock, samples on the rising edge, drives the ACK on fall 11)
//  1 tx_data=8'hED, tx_valid 1 cycle -> clk_oe high for 6000 cycles; bits seen 1,0,1,1,0,1,1,1, parity 1,
//    stop 1; ACK 0 -> exactly one tx_done pulse; busy falls with it; both oe end at 0.
//  2 tx_data=8'h01 -> model captures byte 0x01 and parity 0; tx_done pulses once.
//  3 model withholds the ACK (dat stays 1 on fall 11) -> tx_error pulses once, tx_done does not, IDLE.
//  4 model never clocks after the inhibit -> tx_error pulses after 750000 cycles; both oe=0.
//  5 rst_n low at fall 5 -> oe=0 with no clock edge needed, tx_ready=1; a new 8'hFF send then completes normally.
//  6 tx_valid held high during a transfer of 8'hF4 -> exactly one frame sent; a second frame starts only after tx_done.

Source files
------------

// File: rtl/blackjack_ps2_pkg.sv
// Shared PS/2 definitions for the blackjack keyboard path: transmitter state encoding,
// keyboard command bytes and the frame parity helper.
package blackjack_ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_SEND      = 3'd2,
    ST_ACK       = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the blackjack controller (master) and the PS/2 transmitter (slave).
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_error);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_sync_edge.sv
// Synchronizes one raw PS/2 line and flags its falling edge with a one-cycle pulse.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, clocks one command byte out against
// the device clock and checks the device ACK. Lines are driven only as pull-low enables.
module ps2_host_tx
  import blackjack_ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic           CLOCK_50,
  input  logic           rst_n,
  ps2_host_tx_if.slave   tx_if,
  input  logic           ps2_clk_in,
  input  logic           ps2_dat_in,
  output logic           ps2_clk_oe,
  output logic           ps2_dat_oe
);

  localparam int          INH_W         = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [19:0] TIMEOUT_LIMIT = 20'(TIMEOUT_CYCLES);

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [19:0]      to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             clk_s, clk_fall_s, dat_s, dat_fall_s, timeout_s;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(CLOCK_50), .rst_n(rst_n), .d_in(ps2_clk_in), .level(clk_s), .fall(clk_fall_s)
  );
  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
    .clk(CLOCK_50), .rst_n(rst_n), .d_in(ps2_dat_in), .level(dat_s), .fall(dat_fall_s)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    timeout_s = (to_cnt_q == TIMEOUT_LIMIT);
    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_if.tx_valid) begin
          data_d    = tx_if.tx_data;
          par_d     = odd_parity(tx_if.tx_data);
          bit_cnt_d = 4'd0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        // Start bit goes out in the last inhibit cycle, before the clock is released.
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 2)) begin
          dat_oe_d = 1'b1;
        end
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (clk_fall_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            dat_oe_d = ~par_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end else if (timeout_s) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = ST_ERR;
        end
      end
      ST_ACK: begin
        if (clk_fall_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = dat_s ? ST_ERR : ST_WAIT_IDLE;
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          state_d = ST_DONE;
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
    // Watchdog restarts on every device clock fall and on every state change.
    to_cnt_d = (clk_fall_s || (state_d != state_q)) ? 20'd0 : to_cnt_q + 20'd1;
    ready_d  = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    err_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= 8'h00;
      par_q     <= 1'b0;
      bit_cnt_q <= 4'd0;
      inh_cnt_q <= '0;
      to_cnt_q  <= 20'd0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_if.busy     = busy_q;
  assign tx_if.tx_done  = done_q;
  assign tx_if.tx_error = err_q;
  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_dat_oe     = dat_oe_q;

endmodule
